// File: rtl/hs_bus_sender.sv
// Source side of a req/ack bus synchronizer: holds a captured word on bus_data
// and handshakes it across to another clock domain (4-phase level or 2-phase toggle).
module hs_bus_sender #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TWO_PHASE   = 0,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_req,
  input  logic             bus_ack,
  output logic             done,
  output logic             err,
  input  logic             err_clr,
  output logic [7:0]       xfer_count
);

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

  // In 2-phase mode S_REQ doubles as the single WAIT state; S_REL is unused.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [TW-1:0]          to_q, to_d, to_inc;
  logic                   accept, busy, to_hit;

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus_ack};
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        data_d  = in_data;
        req_d   = (TWO_PHASE != 0) ? ~req_q : 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (TWO_PHASE != 0) begin
          if (ack_s == req_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end
        end else if (ack_s) begin
          req_d   = 1'b0;
          state_d = S_REL;
        end
      end
      S_REL: if (!ack_s) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout only flags a stuck receiver; the handshake keeps waiting.
    busy   = (state_q != S_IDLE);
    to_inc = to_q + 1'b1;
    to_hit = (TIMEOUT_CYC != 0) && busy && (state_d == state_q) &&
             (to_q != TO_MAX) && (to_inc == TO_MAX);
    if (state_d != state_q)          to_d = '0;
    else if (busy && to_q != TO_MAX) to_d = to_inc;
    else                             to_d = to_q;
    if (to_hit)       err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // A stale ack (4-phase) or unmatched toggle (2-phase) blocks new words.
  always_comb begin
    in_ready = 1'b0;
    if (state_q == S_IDLE)
      in_ready = (TWO_PHASE != 0) ? (ack_s == req_q) : !ack_s;
  end

  assign accept     = in_valid & in_ready;
  assign bus_data   = data_q;
  assign bus_req    = req_q;
  assign done       = done_q;
  assign err        = err_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_hs_bus_sender.sv
// Directed bench for hs_bus_sender: a 4-phase instance with a 3-cycle ack loopback
// and timeout 10, plus a 2-phase instance with a 2-cycle ack loopback.
module tb_hs_bus_sender;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv4, ir4, br4, ba4, dn4, er4, ec4;
  logic [7:0] id4, bd4, xc4;
  logic       iv2, ir2, br2, ba2, dn2, er2, ec2;
  logic [7:0] id2, bd2, xc2;
  logic       ack_en, ack_ovr;
  logic [2:0] d4 = '0;
  logic [1:0] d2 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  hs_bus_sender #(.WIDTH(8), .SYNC_STAGES(2), .TWO_PHASE(0), .TIMEOUT_CYC(10)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .bus_data(bd4), .bus_req(br4), .bus_ack(ba4), .done(dn4), .err(er4),
    .err_clr(ec4), .xfer_count(xc4));

  hs_bus_sender #(.WIDTH(8), .SYNC_STAGES(2), .TWO_PHASE(1), .TIMEOUT_CYC(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
    .bus_data(bd2), .bus_req(br2), .bus_ack(ba2), .done(dn2), .err(er2),
    .err_clr(ec2), .xfer_count(xc2));

  // Receiver stand-in: ack is bus_req delayed by whole clk cycles.
  always @(posedge clk) begin
    d4 <= {d4[1:0], br4};
    d2 <= {d2[0], br2};
  end
  assign ba4 = ack_en ? ack_ovr : d4[2];
  assign ba2 = d2[1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; iv4 = 1'b0; iv2 = 1'b0; ec4 = 1'b0; ec2 = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; iv4 = 1'b1; id4 = 8'h99; iv2 = 1'b1; id2 = 8'h99;
    ec4 = 1'b0; ec2 = 1'b0; ack_en = 1'b0; ack_ovr = 1'b0;
    repeat (5) tick();
    n_cmp++; if ({bd4, br4, dn4, er4, xc4} !== 20'h0) begin n_bad++;
      $display("FAIL reset4_outputs: got data=%h req=%b done=%b err=%b cnt=%0d exp all 0", bd4, br4, dn4, er4, xc4); end
    n_cmp++; if ({bd2, br2, dn2, er2, xc2} !== 20'h0) begin n_bad++;
      $display("FAIL reset2_outputs: got data=%h req=%b done=%b err=%b cnt=%0d exp all 0", bd2, br2, dn2, er2, xc2); end
    n_cmp++; if ({ir4, ir2} !== 2'b11) begin n_bad++;
      $display("FAIL reset_ready: got %b%b exp 11", ir4, ir2); end
    iv4 = 1'b0; iv2 = 1'b0; rst = 1'b0;
  endtask

  task automatic test_single();
    int fall_at, done_at, ndone;
    logic held;
    do_reset();
    fall_at = -1; done_at = -1; ndone = 0; held = 1'b1;
    id4 = 8'hAB; iv4 = 1'b1;
    n_cmp++; if (ir4 !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b exp 1", ir4); end
    tick();
    n_cmp++; if ({br4, bd4, ir4} !== {1'b1, 8'hAB, 1'b0}) begin n_bad++;
      $display("FAIL single_accept: got req=%b data=%h rdy=%b exp 1 ab 0", br4, bd4, ir4); end
    iv4 = 1'b0; id4 = 8'h33;
    for (int k = 1; k <= 20; k++) begin
      tick();
      iv4 = (k == 3);
      if (bd4 !== 8'hAB) held = 1'b0;
      if (!br4 && fall_at < 0) fall_at = k;
      if (dn4) begin ndone++; if (done_at < 0) done_at = k; end
    end
    iv4 = 1'b0;
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL single_data_held: got %h exp ab", bd4); end
    n_cmp++; if (fall_at != 6) begin n_bad++; $display("FAIL single_req_fall: got %0d exp 6", fall_at); end
    n_cmp++; if (done_at != 12 || ndone != 1) begin n_bad++;
      $display("FAIL single_done: got at=%0d n=%0d exp at=12 n=1", done_at, ndone); end
    n_cmp++; if (xc4 !== 8'd1) begin n_bad++; $display("FAIL single_count: got %0d exp 1", xc4); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    logic [7:0] seq [3];
    int rise [3];
    int dn [3];
    int nr, nd, idx;
    logic prev;
    w[0] = 8'h55; w[1] = 8'hAA; w[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin seq[i] = 8'h00; rise[i] = -1; dn[i] = -1; end
    do_reset();
    nr = 0; nd = 0; idx = 0; prev = 1'b0;
    id4 = w[0]; iv4 = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (br4 && !prev && nr < 3) begin rise[nr] = k; seq[nr] = bd4; nr++; end
      if (dn4) begin
        if (nd < 3) dn[nd] = k;
        nd++; idx++;
        if (idx < 3) id4 = w[idx]; else iv4 = 1'b0;
      end
      prev = br4;
    end
    iv4 = 1'b0;
    n_cmp++; if (nd != 3 || nr != 3) begin n_bad++; $display("FAIL b2b_counts: got done=%0d req=%0d exp 3 3", nd, nr); end
    n_cmp++; if ({seq[0], seq[1], seq[2]} !== 24'h55AAFF) begin n_bad++;
      $display("FAIL b2b_data: got %h %h %h exp 55 aa ff", seq[0], seq[1], seq[2]); end
    n_cmp++; if (rise[1] != dn[0] + 1 || rise[2] != dn[1] + 1) begin n_bad++;
      $display("FAIL b2b_gap: got rise=%0d,%0d done=%0d,%0d exp rise=done+1", rise[1], rise[2], dn[0], dn[1]); end
    n_cmp++; if (xc4 !== 8'd3) begin n_bad++; $display("FAIL b2b_count: got %0d exp 3", xc4); end
  endtask

  task automatic test_stale_ack();
    int done_at;
    do_reset();
    ack_en = 1'b1; ack_ovr = 1'b1;
    tick(); tick();
    n_cmp++; if (ir4 !== 1'b0) begin n_bad++; $display("FAIL stale_ready: got %b exp 0", ir4); end
    id4 = 8'h12; iv4 = 1'b1;
    repeat (3) tick();
    n_cmp++; if ({br4, bd4, ir4} !== 10'h0) begin n_bad++;
      $display("FAIL stale_no_accept: got req=%b data=%h rdy=%b exp 0 00 0", br4, bd4, ir4); end
    ack_en = 1'b0;
    tick();
    n_cmp++; if (ir4 !== 1'b0) begin n_bad++; $display("FAIL stale_release1: got %b exp 0", ir4); end
    tick();
    n_cmp++; if ({ir4, br4} !== 2'b10) begin n_bad++; $display("FAIL stale_release2: got rdy=%b req=%b exp 1 0", ir4, br4); end
    tick();
    n_cmp++; if ({br4, bd4} !== {1'b1, 8'h12}) begin n_bad++; $display("FAIL stale_send: got req=%b data=%h exp 1 12", br4, bd4); end
    iv4 = 1'b0; done_at = -1;
    for (int k = 1; k <= 30 && done_at < 0; k++) begin tick(); if (dn4) done_at = k; end
    n_cmp++; if (done_at != 12 || xc4 !== 8'd1) begin n_bad++;
      $display("FAIL stale_done: got at=%0d cnt=%0d exp at=12 cnt=1", done_at, xc4); end
  endtask

  task automatic test_two_phase();
    int done_at, total;
    do_reset();
    id2 = 8'hDA; iv2 = 1'b1;
    tick();
    n_cmp++; if ({br2, bd2, ir2} !== {1'b1, 8'hDA, 1'b0}) begin n_bad++;
      $display("FAIL tp_first: got req=%b data=%h rdy=%b exp 1 da 0", br2, bd2, ir2); end
    iv2 = 1'b0; done_at = -1;
    for (int k = 1; k <= 20; k++) begin tick(); if (dn2 && done_at < 0) done_at = k; end
    n_cmp++; if (done_at != 5 || ir2 !== 1'b1) begin n_bad++;
      $display("FAIL tp_first_done: got at=%0d rdy=%b exp at=5 rdy=1", done_at, ir2); end
    id2 = 8'h01; iv2 = 1'b1;
    tick();
    n_cmp++; if ({br2, bd2} !== {1'b0, 8'h01}) begin n_bad++;
      $display("FAIL tp_second: got req=%b data=%h exp 0 01", br2, bd2); end
    iv2 = 1'b0; done_at = -1;
    for (int k = 1; k <= 20 && done_at < 0; k++) begin tick(); if (dn2) done_at = k; end
    n_cmp++; if (done_at != 5 || xc2 !== 8'd2) begin n_bad++;
      $display("FAIL tp_second_done: got at=%0d cnt=%0d exp at=5 cnt=2", done_at, xc2); end
    total = 2; id2 = 8'h5A; iv2 = 1'b1;
    for (int k = 0; k < 3000 && total < 256; k++) begin
      tick();
      if (dn2) begin
        total++;
        if (total == 255) begin
          n_cmp++; if (xc2 !== 8'd255) begin n_bad++; $display("FAIL tp_count255: got %0d exp 255", xc2); end
        end
      end
    end
    iv2 = 1'b0;
    n_cmp++; if (total != 256 || xc2 !== 8'd0) begin n_bad++;
      $display("FAIL tp_wrap: got sends=%0d cnt=%0d exp 256 0", total, xc2); end
  endtask

  task automatic test_timeout();
    logic early, reset_again;
    do_reset();
    ack_en = 1'b1; ack_ovr = 1'b0;
    id4 = 8'h7E; iv4 = 1'b1;
    tick();
    iv4 = 1'b0; early = 1'b0;
    for (int k = 1; k <= 9; k++) begin tick(); if (er4 !== 1'b0) early = 1'b1; end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL to_early: got err before cycle 10 exp 0"); end
    tick();
    n_cmp++; if (er4 !== 1'b1) begin n_bad++; $display("FAIL to_at10: got %b exp 1", er4); end
    n_cmp++; if ({br4, ir4, bd4} !== {1'b1, 1'b0, 8'h7E}) begin n_bad++;
      $display("FAIL to_still_req: got req=%b rdy=%b data=%h exp 1 0 7e", br4, ir4, bd4); end
    repeat (3) tick();
    n_cmp++; if (er4 !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b exp 1", er4); end
    ec4 = 1'b1; tick(); ec4 = 1'b0;
    n_cmp++; if (er4 !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b exp 0", er4); end
    reset_again = 1'b0;
    for (int k = 0; k < 15; k++) begin tick(); if (er4 !== 1'b0) reset_again = 1'b1; end
    n_cmp++; if ({reset_again, br4} !== 2'b01) begin n_bad++;
      $display("FAIL to_no_reset: got reerr=%b req=%b exp 0 1", reset_again, br4); end
    do_reset();
    ec4 = 1'b1; id4 = 8'h7E; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    repeat (9) tick();
    tick();
    n_cmp++; if (er4 !== 1'b1) begin n_bad++; $display("FAIL to_set_wins: got %b exp 1", er4); end
    tick();
    n_cmp++; if (er4 !== 1'b0) begin n_bad++; $display("FAIL to_clr_after: got %b exp 0", er4); end
    ec4 = 1'b0; ack_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack_en = 1'b0;
    id4 = 8'h11; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    repeat (14) tick();
    ack_en = 1'b1; ack_ovr = 1'b0;
    id4 = 8'hC3; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    repeat (10) tick();
    n_cmp++; if ({er4, br4, bd4, xc4} !== {1'b1, 1'b1, 8'hC3, 8'd1}) begin n_bad++;
      $display("FAIL mid_pre: got err=%b req=%b data=%h cnt=%0d exp 1 1 c3 1", er4, br4, bd4, xc4); end
    rst = 1'b1; ack_ovr = 1'b1;
    tick();
    n_cmp++; if ({br4, bd4, er4, xc4, dn4} !== 19'h0) begin n_bad++;
      $display("FAIL mid_reset: got req=%b data=%h err=%b cnt=%0d done=%b exp all 0", br4, bd4, er4, xc4, dn4); end
    rst = 1'b0;
    tick(); tick();
    n_cmp++; if (ir4 !== 1'b0) begin n_bad++; $display("FAIL mid_block: got %b exp 0", ir4); end
    repeat (3) tick();
    n_cmp++; if ({ir4, br4} !== 2'b00) begin n_bad++; $display("FAIL mid_hold: got rdy=%b req=%b exp 0 0", ir4, br4); end
    ack_ovr = 1'b0;
    tick();
    n_cmp++; if (ir4 !== 1'b0) begin n_bad++; $display("FAIL mid_fall1: got %b exp 0", ir4); end
    tick();
    n_cmp++; if (ir4 !== 1'b1) begin n_bad++; $display("FAIL mid_fall2: got %b exp 1", ir4); end
    ack_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stale_ack();
    test_two_phase();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
